seq_ctrl: RTL and testbench

SEQ_CTRL -- requirements
Module: seq_ctrl

---
 rtl/seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback/PC-update and stops on halt or fault.
module seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        imem_ready,
  input  logic        imem_error,
  input  logic [3:0]  icode,
  input  logic        dmem_ready,
  input  logic        dmem_error,
  output logic        imem_req,
  output logic        dec_en,
  output logic        exe_en,
  output logic        wb_en,
  output logic        dmem_req,
  output logic        pc_we,
  output logic [2:0]  stat,
  output logic [3:0]  icode_q,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Bit n set means icode n is in the class: memory = {4,5,8,9,A,B},
  // register writer = {2,3,5,6,8,9,A,B}.
  localparam logic [15:0] MEM_MASK = 16'h0F30;
  localparam logic [15:0] WR_MASK  = 16'h0F6C;

  state_t      state_reg, state_next;
  logic [2:0]  stat_next;
  logic [3:0]  icode_next;
  logic        is_mem, is_wr;

  assign is_mem = MEM_MASK[icode_q];
  assign is_wr  = WR_MASK[icode_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      stat      <= STAT_AOK;
      icode_q   <= 4'd0;
      instr_cnt <= 32'd0;
    end else begin
      state_reg <= state_next;
      stat      <= stat_next;
      icode_q   <= icode_next;
      // Retirement is counted on the PC update; the adder wraps naturally.
      if (state_reg == S_PCUPD)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    stat_next  = stat;
    icode_next = icode_q;
    imem_req   = 1'b0;
    dec_en     = 1'b0;
    exe_en     = 1'b0;
    dmem_req   = 1'b0;
    wb_en      = 1'b0;
    pc_we      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start)
          state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          icode_next = icode;
          if (imem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_FAULT;
          end else if (icode > 4'hB) begin
            stat_next  = STAT_INS;
            state_next = S_FAULT;
          end else if (icode == 4'h0) begin
            stat_next  = STAT_HLT;
            state_next = S_HALT;
          end else begin
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        dec_en     = 1'b1;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        exe_en = 1'b1;
        if (is_mem)
          state_next = S_MEMORY;
        else if (is_wr)
          state_next = S_WRITEBACK;
        else
          state_next = S_PCUPD;
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_FAULT;
          end else if (is_wr) begin
            state_next = S_WRITEBACK;
          end else begin
            state_next = S_PCUPD;
          end
        end
      end
      S_WRITEBACK: begin
        wb_en      = 1'b1;
        state_next = S_PCUPD;
      end
      S_PCUPD: begin
        pc_we      = 1'b1;
        state_next = S_FETCH;
      end
      // Terminal: nothing but rst_n leaves these states.
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Randomized bench for seq_ctrl: a transaction-level model predicts each
// instruction's stage trace, final status and retirement count.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_error = 1'b0;
  logic [3:0]  icode = 4'd0;
  logic        dmem_ready = 1'b0;
  logic        dmem_error = 1'b0;
  logic        imem_req, dec_en, exe_en, wb_en, dmem_req, pc_we;
  logic [2:0]  stat;
  logic [3:0]  icode_q;
  logic [31:0] instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  int txn = 0;

  seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_ready (imem_ready),
    .imem_error (imem_error),
    .icode      (icode),
    .dmem_ready (dmem_ready),
    .dmem_error (dmem_error),
    .imem_req   (imem_req),
    .dec_en     (dec_en),
    .exe_en     (exe_en),
    .wb_en      (wb_en),
    .dmem_req   (dmem_req),
    .pc_we      (pc_we),
    .stat       (stat),
    .icode_q    (icode_q),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Stage code seen this cycle: 0 none, 1 F, 2 D, 3 E, 4 M, 5 W, 6 P.
  function automatic int stage_code();
    if (imem_req) return 1;
    if (dec_en)   return 2;
    if (exe_en)   return 3;
    if (dmem_req) return 4;
    if (wb_en)    return 5;
    if (pc_we)    return 6;
    return 0;
  endfunction

  function automatic logic [5:0] enables();
    return {imem_req, dec_en, exe_en, dmem_req, wb_en, pc_we};
  endfunction

  function automatic bit in_set(input logic [3:0] ic, input int unsigned lst[$]);
    foreach (lst[i]) if (ic == lst[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Asynchronous reset pulse landing between clock edges.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_enables", {26'd0, enables()}, 32'd0);
    check_eq("rst_stat", {29'd0, stat}, 32'd1);
    check_eq("rst_icode_q", {28'd0, icode_q}, 32'd0);
    check_eq("rst_cnt", instr_cnt, 32'd0);
    model_cnt = 0;
    start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge with the DUT in FETCH. result: 0 retired, 1 terminal, 2 aborted.
  task automatic run_instr(input logic [3:0] ic, input bit ierr, input int iw,
                           input bit derr, input int dw, input bit abort_mem,
                           output int result);
    int exp_q[$];
    int obs_q[$];
    int fcnt = 0, mcnt = 0, code = 0;
    int exp_stat;
    bit done = 1'b0;
    bit mem_i = in_set(ic, '{4, 5, 8, 9, 10, 11});
    bit wr_i  = in_set(ic, '{2, 3, 5, 6, 8, 9, 10, 11});

    // Expected trace straight from the instruction-class rules.
    repeat (iw + 1) exp_q.push_back(1);
    if (ierr)            exp_stat = 3;
    else if (ic > 4'hB)  exp_stat = 4;
    else if (ic == 4'h0) exp_stat = 2;
    else begin
      exp_stat = 1;
      exp_q.push_back(2);
      exp_q.push_back(3);
      if (mem_i) begin
        repeat (dw + 1) exp_q.push_back(4);
        if (derr) exp_stat = 3;
      end
      if (exp_stat == 1) begin
        if (wr_i) exp_q.push_back(5);
        exp_q.push_back(6);
      end
    end

    result = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      check_eq("onehot", {31'd0, $countones(enables()) <= 1}, 32'd1);
      code = stage_code();
      if (code == 0) begin
        result = 1;
        done = 1'b1;
        break;
      end
      obs_q.push_back(code);
      if (abort_mem && code == 4 && mcnt == 1) begin
        reset_pulse();
        result = 2;
        $display("txn %0d icode=%h aborted by reset in MEMORY", txn, ic);
        txn++;
        return;
      end
      start      = 1'($urandom_range(0, 1));
      imem_ready = (code == 1 && fcnt == iw);
      imem_error = imem_ready & ierr;
      icode      = imem_ready ? ic : 4'($urandom);
      dmem_ready = (code == 4 && mcnt == dw);
      dmem_error = dmem_ready & derr;
      if (code == 1) fcnt++;
      if (code == 4) mcnt++;
      @(negedge clk);
      if (code == 6) begin
        done = 1'b1;
        break;
      end
    end
    start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
    check_eq("no_timeout", {31'd0, done}, 32'd1);

    check_eq("trace_len", obs_q.size(), exp_q.size());
    foreach (exp_q[i])
      check_eq("trace_stage", (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
    if (exp_stat == 1) model_cnt++;
    check_eq("stat", {29'd0, stat}, exp_stat);
    check_eq("icode_q", {28'd0, icode_q}, {28'd0, ic});
    check_eq("instr_cnt", instr_cnt, model_cnt);
    check_eq("outcome", result, (exp_stat == 1) ? 0 : 1);
    $display("txn %0d icode=%h ierr=%0d iw=%0d derr=%0d dw=%0d cycles=%0d stat=%0d cnt=%0d",
             txn, ic, ierr, iw, derr, dw, obs_q.size(), stat, instr_cnt);
    txn++;
  endtask

  // Terminal state must ignore everything until reset.
  task automatic hold_terminal(input logic [3:0] ic, input logic [2:0] st);
    repeat (4) begin
      start      = 1'($urandom_range(0, 1));
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      icode      = 4'($urandom_range(1, 3));
      @(negedge clk);
      check_eq("term_enables", {26'd0, enables()}, 32'd0);
      check_eq("term_stat", {29'd0, stat}, {29'd0, st});
      check_eq("term_icode_q", {28'd0, icode_q}, {28'd0, ic});
      check_eq("term_cnt", instr_cnt, model_cnt);
    end
    start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_instr(input logic [3:0] ic, input bit ierr, input int iw,
                          input bit derr, input int dw, input bit abort_mem);
    int res;
    logic [2:0] st;
    run_instr(ic, ierr, iw, derr, dw, abort_mem, res);
    if (res == 1) begin
      st = stat;
      hold_terminal(ic, st);
      reset_pulse();
      do_start();
    end else if (res == 2) begin
      do_start();
    end
  endtask

  initial begin
    int sel;
    logic [3:0] ic;
    repeat (2) @(negedge clk);
    #1;
    check_eq("init_enables", {26'd0, enables()}, 32'd0);
    check_eq("init_stat", {29'd0, stat}, 32'd1);
    check_eq("init_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // IDLE waits for start even with memory responses present.
    imem_ready = 1'b1; icode = 4'h1;
    repeat (2) begin
      @(negedge clk);
      check_eq("idle_enables", {26'd0, enables()}, 32'd0);
    end
    imem_ready = 1'b0;
    do_start();

    // Directed cases.
    do_instr(4'h1, 0, 0, 0, 0, 0);
    do_instr(4'h5, 0, 3, 0, 2, 0);
    do_instr(4'h4, 0, 0, 0, 0, 0);
    do_instr(4'h2, 0, 0, 0, 0, 0);
    do_instr(4'h8, 0, 0, 0, 0, 0);
    do_instr(4'h0, 0, 1, 0, 0, 0);
    do_instr(4'h0, 1, 0, 0, 0, 0);
    do_instr(4'hC, 0, 0, 0, 0, 0);
    do_instr(4'hA, 0, 0, 1, 0, 0);
    do_instr(4'h9, 0, 1, 0, 4, 1);
    do_instr(4'h7, 0, 0, 0, 0, 0);

    // Randomized stream.
    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom_range(0, 9));
      ic  = (sel < 8) ? 4'($urandom_range(1, 11)) : 4'($urandom_range(0, 15));
      do_instr(ic, $urandom_range(0, 24) == 0, int'($urandom_range(0, 3)),
               $urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
               $urandom_range(0, 14) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
